// File: rtl/ssdisp_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-slices one shared decoder across
// NUM_DIGITS digit drivers, with dark guard slots and double-buffered frame updates.
module ssdisp_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    run,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              dec_in,
  output logic                    dec_enable,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    commit,
  output logic                    frame_start
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] act;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pflag;
  // idle marks the parked position after reset or run low; leaving it opens a frame
  logic                    idle;

  logic blank_done, slot_done, boundary;

  assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
  assign slot_done  = (state == SHOW) && (cnt == SHOW_LAST);
  assign boundary   = idle || (slot_done && (idx == IDX_LAST));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= BLANK;
      idx         <= '0;
      cnt         <= '0;
      act         <= '0;
      pend        <= '0;
      pflag       <= 1'b0;
      idle        <= 1'b1;
      commit      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      commit      <= 1'b0;
      frame_start <= 1'b0;
      if (load) begin
        pend  <= load_data;
        pflag <= 1'b1;
      end
      if (!run) begin
        state <= BLANK;
        idx   <= '0;
        cnt   <= '0;
        idle  <= 1'b1;
      end else begin
        if (idle) begin
          // first BLANK cycle of digit 0 is the cycle right after leaving idle
          idle <= 1'b0;
        end else begin
          case (state)
            BLANK: begin
              if (blank_done) begin
                state <= SHOW;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            SHOW: begin
              if (slot_done) begin
                state <= BLANK;
                cnt   <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: state <= BLANK;
          endcase
        end
        // a load landing on the boundary edge bypasses pend so the latest data wins
        if (boundary) begin
          frame_start <= 1'b1;
          if (load || pflag) begin
            act    <= load ? load_data : pend;
            pflag  <= 1'b0;
            commit <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    dig_sel    = '0;
    dec_in     = '0;
    dec_enable = 1'b0;
    if (state == SHOW) begin
      dig_sel[idx] = 1'b1;
      dec_in       = act[{idx, 2'b00} +: 4];
      dec_enable   = digit_en[idx];
    end
  end

endmodule

// File: tb/tb_ssdisp_scan_ctrl.sv
// Directed bench for ssdisp_scan_ctrl (4 digits, SHOW=3, BLANK=2): frame-position
// model checks every output cycle by cycle across loads, masks, run drop and reset.
module tb_ssdisp_scan_ctrl;
  localparam int ND    = 4;
  localparam int SC    = 3;
  localparam int BC    = 2;
  localparam int SLOT  = SC + BC;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          run = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_data = '0;
  logic [3:0]    digit_en = 4'hF;
  logic [3:0]    dec_in;
  logic          dec_enable;
  logic [3:0]    dig_sel;
  logic          commit;
  logic          frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  ssdisp_scan_ctrl #(.NUM_DIGITS(ND), .SHOW_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .nrst(nrst), .run(run), .load(load), .load_data(load_data),
    .digit_en(digit_en), .dec_in(dec_in), .dec_enable(dec_enable),
    .dig_sel(dig_sel), .commit(commit), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic check_dark(input string tag);
    chk({tag, " dig_sel"}, dig_sel, 0);
    chk({tag, " dec_in"}, dec_in, 0);
    chk({tag, " dec_en"}, dec_enable, 0);
    chk({tag, " commit"}, commit, 0);
    chk({tag, " fstart"}, frame_start, 0);
  endtask

  // Called at frame position 0; returns at position 0 of the next frame.
  task automatic run_frame(input string tag, input logic [15:0] exp_act, input logic [3:0] en,
                           input logic exp_commit, input int lk1, input logic [15:0] ld1,
                           input int lk2, input logic [15:0] ld2);
    digit_en = en;
    for (int k = 0; k < FRAME; k++) begin
      int d;
      int p;
      d = k / SLOT;
      p = k % SLOT;
      chk($sformatf("%s k%0d fstart", tag, k), frame_start, (k == 0) ? 1 : 0);
      chk($sformatf("%s k%0d commit", tag, k), commit, (k == 0 && exp_commit) ? 1 : 0);
      if (p < BC) begin
        chk($sformatf("%s k%0d dig_sel", tag, k), dig_sel, 0);
        chk($sformatf("%s k%0d dec_in", tag, k), dec_in, 0);
        chk($sformatf("%s k%0d dec_en", tag, k), dec_enable, 0);
      end else begin
        chk($sformatf("%s k%0d dig_sel", tag, k), dig_sel, 32'd1 << d);
        chk($sformatf("%s k%0d dec_in", tag, k), dec_in, (exp_act >> (4 * d)) & 16'hF);
        chk($sformatf("%s k%0d dec_en", tag, k), dec_enable, en[d]);
      end
      load      = (k == lk1) || (k == lk2);
      load_data = (k == lk2) ? ld2 : ld1;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    run = 1'b1;
    adv(2);
    check_dark("reset");
    nrst = 1'b1;
    tick();

    run_frame("fA", 16'h0000, 4'hF, 1'b0, 5, 16'h1234, -1, 16'h0);
    run_frame("fB", 16'h1234, 4'hF, 1'b1, 3, 16'hAAAA, 10, 16'h5555);
    run_frame("fC", 16'h5555, 4'hF, 1'b1, 19, 16'hBEEF, -1, 16'h0);
    run_frame("fD", 16'hBEEF, 4'hF, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame("fE", 16'hBEEF, 4'b0101, 1'b0, -1, 16'h0, -1, 16'h0);

    // live digit_en mask and run drop mid-frame
    digit_en = 4'hF;
    chk("fF fstart", frame_start, 1);
    chk("fF commit", commit, 0);
    adv(3);
    digit_en = 4'hE;
    #1;
    chk("live mask dec_en", dec_enable, 0);
    chk("live mask dig_sel", dig_sel, 4'b0001);
    digit_en = 4'hF;
    #1;
    chk("live unmask dec_en", dec_enable, 1);
    adv(9);
    chk("d2 dig_sel", dig_sel, 4'b0100);
    chk("d2 dec_in", dec_in, 4'hE);
    run = 1'b0;
    load = 1'b1;
    load_data = 16'h0F0F;
    tick();
    load = 1'b0;
    check_dark("run_lo");
    adv(3);
    check_dark("run_lo_hold");
    run = 1'b1;
    tick();
    run_frame("fG", 16'h0F0F, 4'hF, 1'b1, -1, 16'h0, -1, 16'h0);

    // async reset mid-SHOW of digit 1
    adv(7);
    chk("pre_rst dig_sel", dig_sel, 4'b0010);
    #2;
    nrst = 1'b0;
    #1;
    check_dark("async_rst");
    digit_en = 4'b1110;
    adv(2);
    check_dark("in_rst");
    nrst = 1'b1;
    tick();
    run_frame("fH", 16'h0000, 4'b1110, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssdisp_scan_ctrl.md
SSDISP_SCAN_CTRL -- requirements
Module: ssdisp_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits sharing one ssdec decoder (range 2..8).
REQ-002 Parameter SHOW_CYCLES, default 1000, clock cycles each digit is driven per scan slot (>=1).
REQ-003 Parameter BLANK_CYCLES, default 2, anti-ghosting cycles with all digits off before each slot (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 nrst  input  1  reset, asynchronous assert, active-low.
REQ-006 run  input  1  scanning enable; low forces display dark and restarts the scan.
REQ-007 load  input  1  one-cycle strobe; capture load_data as the next frame.
REQ-008 load_data  input  4*NUM_DIGITS  digit nibbles, digit i at bits [4i+3:4i].
REQ-009 digit_en  input  NUM_DIGITS  per-digit blank mask, sampled live; 0 = digit dark.
REQ-010 dec_in  output  4  nibble to the shared ssdec in port.
REQ-011 dec_enable  output  1  to ssdec enable port.
REQ-012 dig_sel  output  NUM_DIGITS  one-hot active-high digit driver select.
REQ-013 commit  output  1  one-cycle pulse: pending frame copied to the displayed frame.
REQ-014 frame_start  output  1  one-cycle pulse at the first BLANK cycle of digit 0.

Function
REQ-015 Two states: BLANK, SHOW; registers: state, digit index idx, slot counter cnt, active frame act, pending frame pend, pending flag pflag.
REQ-016 BLANK: dig_sel=0, dec_enable=0, dec_in=0; lasts exactly BLANK_CYCLES cycles, then SHOW with cnt cleared.
REQ-017 SHOW: dig_sel one-hot at bit idx, dec_in=act nibble idx, dec_enable=digit_en[idx]; lasts exactly SHOW_CYCLES cycles, then BLANK.
REQ-018 On SHOW->BLANK, idx increments; idx=NUM_DIGITS-1 wraps to 0 (frame boundary).
REQ-019 Frame period = NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) cycles; no cycle with two dig_sel bits set.
REQ-020 load=1: pend<=load_data, pflag<=1 next edge; later loads overwrite earlier uncommitted ones (latest wins).
REQ-021 At frame boundary with pflag=1: act<=pend, pflag<=0, commit=1 during the first BLANK cycle of the new frame.
REQ-022 load coincident with frame boundary: the coincident load_data is committed (bypass), pflag ends 0, single commit pulse.
REQ-023 No frame boundary without pending data produces no commit; act never changes mid-frame.
REQ-024 frame_start asserted in the first BLANK cycle of idx=0, including the first frame after reset or run rising.
REQ-025 run=0: next edge forces state=BLANK, idx=0, cnt=0; outputs dark; commit suppressed; load still captured into pend.
REQ-026 run 0->1: scanning resumes from BLANK idx 0; pending data commits at the first frame_start (commit and frame_start same cycle).
REQ-027 digit_en change mid-slot takes effect on dec_enable the same cycle (combinational); dig_sel unaffected.
REQ-028 All outputs except dec_enable's digit_en term are registered or decoded from registers only; no path from load/load_data to outputs.

Reset
REQ-029 nrst=0 immediately: state=BLANK, idx=0, cnt=0, act=0, pend=0, pflag=0, dig_sel=0, dec_in=0, dec_enable=0, commit=0, frame_start=0.
REQ-030 nrst deassert mid-slot or mid-load: load on the release edge is captured; first frame_start occurs in the first cycle with run=1 after release.

Verification
REQ-031 NUM_DIGITS=4, SHOW=3, BLANK=2, run=1, digit_en=4'hF, load 16'h1234 -> commit after first frame; digits 0..3 show 4,3,2,1; period 20 cycles; 2 dark cycles between slots.
REQ-032 Loads 16'hAAAA then 16'h5555 within one frame -> exactly one commit; act=16'h5555; 16'hAAAA never displayed.
REQ-033 load 16'hBEEF in the last SHOW cycle of digit 3 -> commit next cycle; digit 0 shows F in that frame.
REQ-034 digit_en=4'b0101 -> dec_enable high only in slots of digits 0 and 2; dig_sel still scans all four.
REQ-035 run dropped during digit 2 slot -> next cycle all dark, idx=0; run raised -> frame_start within 1 cycle, digit 0 shown after 2 BLANK cycles.
REQ-036 nrst pulsed low mid-SHOW of digit 1 -> outputs zero asynchronously; act=0; after release, digit 0 shows 0 with dec_enable per digit_en.
